// File: rtl/command_buffer.sv
// command_buffer: circular command FIFO with RUN/HALT delivery control and sticky error flags.
package command_buffer_pkg;
  typedef struct packed {
    logic [3:0]  cmd;
    logic [13:0] x_value;
    logic [13:0] y_value;
  } command_t;
endpackage

module command_buffer
  import command_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  command_t                 wr_command,
  output logic                     wr_ready,
  input  logic                     controller_ready,
  input  logic                     block,
  output command_t                 command_out,
  output logic                     memory_ready,
  input  logic                     resume,
  output logic                     program_done,
  output logic                     overflow,
  output logic                     bad_cmd,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] M2 = 4'd6;
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_next;
  command_t mem [DEPTH];
  command_t head;
  logic [AW-1:0] wp, rp;
  logic empty, wr, is_m2, is_bad, discard, deliver, pop;
  always_comb begin
    head = mem[rp];
    empty = level == '0;
    wr_ready = level != (AW+1)'(DEPTH);
    wr = wr_valid & wr_ready;
    command_out = empty ? '0 : head;
    is_m2 = head.cmd == M2;
    is_bad = head.cmd > 4'd8;
    memory_ready = state == RUN & ~empty & ~is_m2 & ~is_bad;
    deliver = memory_ready & controller_ready & ~block;
    // M2 and undefined codes are consumed internally, never shown to the consumer
    discard = state == RUN & ~empty & (is_m2 | is_bad);
    pop = deliver | discard;
    program_done = state == HALT;
    state_next = state == RUN ? (discard & is_m2 ? HALT : RUN) : (resume ? RUN : HALT);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wp <= '0;
      rp <= '0;
      level <= '0;
      overflow <= 1'b0;
      bad_cmd <= 1'b0;
    end else begin
      state <= state_next;
      wp <= wr ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      level <= level + (AW+1)'(wr) - (AW+1)'(pop);
      overflow <= overflow | (wr_valid & ~wr_ready);
      bad_cmd <= bad_cmd | (discard & is_bad);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_command;
endmodule
